// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM state
// encodings, error-cause codes and the request classification helper.
package dmem_responder_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MISALIGN = 3'd1,
    ERR_RANGE    = 3'd2,
    ERR_RW_BOTH  = 3'd3,
    ERR_NO_OP    = 3'd4
  } err_cause_e;

  // The first matching cause wins; any non-NONE result rejects the access.
  function automatic err_cause_e check_req(input logic [WORD_W-1:0] addr,
                                           input logic              rd,
                                           input logic              wr,
                                           input int unsigned       addr_w);
    logic [WORD_W-1:0] hi;
    hi = addr >> (addr_w + 2);
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if (hi != '0)           return ERR_RANGE;
    if (rd && wr)           return ERR_RW_BOTH;
    if (!rd && !wr)         return ERR_NO_OP;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised data RAM: asynchronous read port, synchronous write port.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array deliberately has no reset; clearing it would turn
  // the RAM into a huge register file and contents must survive rst anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MIPS core's DM_CS/DM_R/DM_W
// port: stalls the core while an access is in flight, flags bad requests.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_CS,
  input  logic              DM_R,
  input  logic              DM_W,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  dmem_state_e       state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] word_q;
  logic [WORD_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;
  err_cause_e        cause_q;

  err_cause_e        req_cause;
  logic              accept;
  logic              enter_resp;
  logic              resp_bad;
  logic              resp_rd;
  logic [ADDR_W-1:0] rd_idx;
  logic [WORD_W-1:0] arr_rdata;
  logic              arr_we;

  assign req_cause = check_req(addr, DM_R, DM_W, ADDR_W);
  assign accept    = (state == ST_IDLE) && DM_CS;

  // With zero wait states RESP is entered straight from the accept edge, so
  // the read index and error verdict must come from the live request.
  assign enter_resp = (accept && NO_WAIT) || (state == ST_WAIT && cnt == 4'd1);
  assign resp_bad   = (state == ST_IDLE) ? (req_cause != ERR_NONE) : (cause_q != ERR_NONE);
  assign resp_rd    = (state == ST_IDLE) ? DM_R : read_q;
  assign rd_idx     = (state == ST_IDLE) ? addr[ADDR_W+1:2] : word_q;

  assign stall  = (state == ST_IDLE) ? DM_CS : (state == ST_WAIT);
  assign arr_we = (state == ST_RESP) && write_q && (cause_q == ERR_NONE);

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (word_q),
    .wdata (wdata_q),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  // NOTE: every register here uses non-blocking assignment so all of them
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      cause_q <= ERR_NONE;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= enter_resp;
      err  <= enter_resp && resp_bad;
      // rdata only moves on a load or a rejected access; stores leave it held.
      if (enter_resp && (resp_bad || resp_rd)) begin
        rdata <= resp_bad ? '0 : arr_rdata;
      end

      case (state)
        ST_IDLE: begin
          if (DM_CS) begin
            word_q  <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            read_q  <= DM_R;
            write_q <= DM_W;
            cause_q <= req_cause;
            cnt     <= WAIT_INIT;
            state   <= NO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
